// File: rtl/access_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | access_pkg                                                           |
// | Shared types and constants for the door-access PIN entry front end:  |
// | FSM state encoding, default PIN width, failure-counter width and a   |
// | small helper for sizing the shared cycle timer.                      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package access_pkg;

   // Default PIN width (bits, and key presses per entry).
   localparam int c_pin_w = 4;

   // Width of the consecutive-failure counter; saturates at all-ones.
   localparam int c_fail_w = 3;
   localparam logic [c_fail_w-1:0] c_fail_max = '1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_PRESENT = 3'd2,
      ST_GRANT   = 3'd3,
      ST_DENY    = 3'd4,
      ST_LOCKOUT = 3'd5
   } state_t;

   // Largest of three periods; sizes the one timer shared by all of them.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pin_entry_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pin_entry_ctrl_if                                                    |
// | Bus between the PIN entry controller and the access checker.         |
// |   has_access : request, held while the PIN is being checked          |
// |   input_pin  : assembled PIN presented to the checker                |
// |   welcome    : checker response, 1 = PIN matches                     |
// | master = controller side, slave = checker side.                      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface pin_entry_ctrl_if
   import access_pkg::*;
#(
   parameter int PIN_W = c_pin_w
);
   logic             has_access;
   logic [PIN_W-1:0] input_pin;
   logic             welcome;

   modport master (
      output has_access,
      output input_pin,
      input  welcome
   );

   modport slave (
      input  has_access,
      input  input_pin,
      output welcome
   );
endinterface
`default_nettype wire

// File: rtl/down_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | down_counter                                                         |
// | Loadable cycle timer. A load writes load_val; otherwise the count    |
// | decrements until it reaches zero and then holds there.               |
// |   clk, rst_n : clock, asynchronous active-low reset                  |
// |   load       : load load_val this cycle                              |
// |   load_val   : value to load (period - 1 gives period cycles)        |
// |   zero       : count is zero                                         |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module down_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             zero
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/pin_entry_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pin_entry_ctrl                                                       |
// | Collects a PIN serially (MSB first) while a card is present,         |
// | presents it to the access checker, drives the door unlock strobe     |
// | on a match, counts consecutive failures and enforces a lockout.      |
// |   clk, rst_n : clock, asynchronous active-low reset                  |
// |   card_ok    : valid card present (entry allowed only while high)    |
// |   key_valid  : one-cycle strobe qualifying key_bit                   |
// |   key_bit    : PIN bit, MSB first                                    |
// |   clear      : abort the current entry                               |
// |   chk        : checker bus (has_access, input_pin, welcome)          |
// |   unlock     : door unlock, UNLOCK_CYCLES long                       |
// |   locked     : lockout active                                        |
// |   fail_cnt   : consecutive failure count                             |
// |   busy       : controller not idle                                   |
// | PIN_W must be >= 2. All outputs are registered.                      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module pin_entry_ctrl
   import access_pkg::*;
#(
   parameter int PIN_W         = c_pin_w,
   parameter int MAX_TRIES     = 3,
   parameter int RESP_WAIT     = 2,
   parameter int UNLOCK_CYCLES = 8,
   parameter int LOCK_CYCLES   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 card_ok,
   input  logic                 key_valid,
   input  logic                 key_bit,
   input  logic                 clear,
   pin_entry_ctrl_if.master     chk,
   output logic                 unlock,
   output logic                 locked,
   output logic [c_fail_w-1:0]  fail_cnt,
   output logic                 busy
);

   localparam int c_tmr_w  = $clog2(max3(RESP_WAIT, UNLOCK_CYCLES, LOCK_CYCLES) + 1);
   localparam int c_bcnt_w = $clog2(PIN_W + 1);

   // Timer loads are period-1: the state exits in the cycle the timer reads zero.
   localparam logic [c_tmr_w-1:0]  c_resp_ld   = c_tmr_w'(RESP_WAIT - 1);
   localparam logic [c_tmr_w-1:0]  c_unlock_ld = c_tmr_w'(UNLOCK_CYCLES - 1);
   localparam logic [c_tmr_w-1:0]  c_lock_ld   = c_tmr_w'(LOCK_CYCLES - 1);
   localparam logic [c_bcnt_w-1:0] c_last_bit  = c_bcnt_w'(PIN_W - 1);
   localparam logic [c_fail_w-1:0] c_max_tries = c_fail_w'(MAX_TRIES);

   state_t                r_state,  w_state_nxt;
   logic [PIN_W-1:0]      r_shreg,  w_shreg_nxt;
   logic [c_bcnt_w-1:0]   r_bcnt,   w_bcnt_nxt;
   logic [PIN_W-1:0]      r_pin,    w_pin_nxt;
   logic                  r_access, w_access_nxt;
   logic                  r_unlock, w_unlock_nxt;
   logic                  r_locked, w_locked_nxt;
   logic [c_fail_w-1:0]   r_fail,   w_fail_nxt;
   logic                  r_busy;
   logic [c_fail_w-1:0]   w_fail_inc;
   logic                  w_tmr_load;
   logic [c_tmr_w-1:0]    w_tmr_val;
   logic                  w_tmr_zero;

   down_counter #(
      .WIDTH (c_tmr_w)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (w_tmr_load),
      .load_val (w_tmr_val),
      .zero     (w_tmr_zero)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_shreg_nxt  = r_shreg;
      w_bcnt_nxt   = r_bcnt;
      w_pin_nxt    = r_pin;
      w_access_nxt = r_access;
      w_unlock_nxt = r_unlock;
      w_locked_nxt = r_locked;
      w_fail_nxt   = r_fail;
      w_tmr_load   = 1'b0;
      w_tmr_val    = '0;
      w_fail_inc   = (r_fail == c_fail_max) ? r_fail : r_fail + 1'b1;

      case (r_state)
         ST_IDLE: begin
            if (card_ok && key_valid) begin
               w_shreg_nxt = {{(PIN_W-1){1'b0}}, key_bit};
               w_bcnt_nxt  = c_bcnt_w'(1);
               w_state_nxt = ST_COLLECT;
            end
         end

         ST_COLLECT: begin
            // Abort wins over a key arriving in the same cycle.
            if (clear || !card_ok) begin
               w_shreg_nxt = '0;
               w_bcnt_nxt  = '0;
               w_state_nxt = ST_IDLE;
            end else if (key_valid) begin
               if (r_bcnt == c_last_bit) begin
                  w_pin_nxt    = {r_shreg[PIN_W-2:0], key_bit};
                  w_access_nxt = 1'b1;
                  w_shreg_nxt  = '0;
                  w_bcnt_nxt   = '0;
                  w_tmr_load   = 1'b1;
                  w_tmr_val    = c_resp_ld;
                  w_state_nxt  = ST_PRESENT;
               end else begin
                  w_shreg_nxt = {r_shreg[PIN_W-2:0], key_bit};
                  w_bcnt_nxt  = r_bcnt + 1'b1;
               end
            end
         end

         ST_PRESENT: begin
            // welcome is only looked at in the final wait cycle; unlock is
            // raised on the same edge so it starts RESP_WAIT+1 cycles after
            // the last key.
            if (w_tmr_zero) begin
               w_access_nxt = 1'b0;
               if (chk.welcome) begin
                  w_unlock_nxt = 1'b1;
                  w_fail_nxt   = '0;
                  w_tmr_load   = 1'b1;
                  w_tmr_val    = c_unlock_ld;
                  w_state_nxt  = ST_GRANT;
               end else begin
                  w_state_nxt  = ST_DENY;
               end
            end
         end

         ST_GRANT: begin
            if (w_tmr_zero) begin
               w_unlock_nxt = 1'b0;
               w_state_nxt  = ST_IDLE;
            end
         end

         ST_DENY: begin
            w_fail_nxt = w_fail_inc;
            if (w_fail_inc >= c_max_tries) begin
               w_locked_nxt = 1'b1;
               w_tmr_load   = 1'b1;
               w_tmr_val    = c_lock_ld;
               w_state_nxt  = ST_LOCKOUT;
            end else begin
               w_state_nxt  = ST_IDLE;
            end
         end

         ST_LOCKOUT: begin
            if (w_tmr_zero) begin
               w_locked_nxt = 1'b0;
               w_fail_nxt   = '0;
               w_state_nxt  = ST_IDLE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_shreg  <= '0;
         r_bcnt   <= '0;
         r_pin    <= '0;
         r_access <= 1'b0;
         r_unlock <= 1'b0;
         r_locked <= 1'b0;
         r_fail   <= '0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_shreg  <= w_shreg_nxt;
         r_bcnt   <= w_bcnt_nxt;
         r_pin    <= w_pin_nxt;
         r_access <= w_access_nxt;
         r_unlock <= w_unlock_nxt;
         r_locked <= w_locked_nxt;
         r_fail   <= w_fail_nxt;
         r_busy   <= (w_state_nxt != ST_IDLE);
      end
   end

   assign chk.has_access = r_access;
   assign chk.input_pin  = r_pin;
   assign unlock         = r_unlock;
   assign locked         = r_locked;
   assign fail_cnt       = r_fail;
   assign busy           = r_busy;

endmodule
`default_nettype wire

// File: doc/pin_entry_ctrl.md
Name: pin_entry_ctrl

Overview:
Front-end controller for the door access checker. It collects a PIN serially from the keypad, gated by a card-accepted flag. It drives the checker's access request and PIN bus, samples the checker's welcome response, and drives the door-unlock strobe. It also counts failed attempts and enforces a lockout period after repeated failures.

Parameters:
PIN_W, 4, PIN width in bits; also the number of key presses per entry
MAX_TRIES, 3, consecutive failures that trigger lockout (range 1..7)
RESP_WAIT, 2, cycles the request is held before welcome is sampled (>=1)
UNLOCK_CYCLES, 8, cycles unlock stays high after a grant (>=1)
LOCK_CYCLES, 16, lockout duration in cycles (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
card_ok  in  1  level: valid card present; entry is allowed only while high
key_valid  in  1  one-cycle strobe: key_bit is valid this cycle
key_bit  in  1  PIN bit, MSB first
clear  in  1  abort the current entry
has_access  out  1  request to the checker
input_pin  out  PIN_W  assembled PIN presented to the checker
welcome  in  1  checker response; 1 = PIN matches
unlock  out  1  door unlock
locked  out  1  lockout active
fail_cnt  out  3  consecutive failure count
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE. has_access=0, input_pin=0, unlock=0, locked=0, fail_cnt=0, all counters=0. Reset mid-operation aborts immediately; no unlock is produced.
- All outputs are registered and update on the rising edge of clk.
- States: IDLE, COLLECT, PRESENT, GRANT, DENY, LOCKOUT.
- IDLE:
  - card_ok=1 and key_valid=1 -> shift in key_bit, set bit count=1, go to COLLECT.
  - key_valid while card_ok=0 is ignored.
- COLLECT:
  - Each key_valid shifts: shreg <= {shreg[PIN_W-2:0], key_bit}.
  - When the PIN_W-th bit is accepted, load input_pin, set has_access=1, go to PRESENT.
  - clear=1 or card_ok=0 -> discard shreg, go to IDLE; fail_cnt unchanged.
  - clear has priority over key_valid in the same cycle.
- PRESENT:
  - has_access and input_pin are held stable for RESP_WAIT cycles.
  - welcome is sampled on the last of those cycles.
  - welcome=1 -> GRANT. welcome=0 -> DENY.
  - has_access drops to 0 on exit. input_pin is held until the next entry begins.
  - clear, key_valid and card_ok are ignored in this state.
- GRANT:
  - unlock=1 for exactly UNLOCK_CYCLES cycles.
  - fail_cnt cleared to 0 on entry.
  - Then go to IDLE.
- DENY (1 cycle):
  - fail_cnt is incremented, saturating at 7.
  - If the new count is >= MAX_TRIES -> LOCKOUT; else -> IDLE.
- LOCKOUT:
  - locked=1 for LOCK_CYCLES cycles; all key input is ignored.
  - On exit, fail_cnt=0 and locked=0; go to IDLE.
- Unlock timing: a correct PIN gives unlock high starting RESP_WAIT+1 cycles after the cycle in which the last key_valid is accepted.
- A key_valid arriving in the cycle the FSM returns to IDLE is accepted as the first bit of a new entry.

Decomposition:
- Shared package access_pkg holds:
  - state enum (IDLE..LOCKOUT)
  - PIN_W default
  - fail_cnt width constant (3)
- One natural sub-module: down_counter, a loadable cycle timer with a zero flag. It is instantiated for the RESP_WAIT, UNLOCK_CYCLES and LOCK_CYCLES timers (one shared instance is acceptable, since these periods never overlap).

Test Plan:
1. Reset -> all outputs 0. card_ok=1, keys 1,1,1,1, welcome tied to (input_pin==4'hF) -> input_pin=4'hF, has_access high for 2 cycles, then unlock high 8 cycles, fail_cnt=0.
2. Keys 1,0,1,0 with welcome=0 -> input_pin=4'hA, no unlock, fail_cnt=1, busy returns to 0.
3. Three consecutive wrong PINs -> fail_cnt reaches 3, locked=1 for 16 cycles. key_valid strobes during lockout have no effect. Afterwards locked=0 and fail_cnt=0.
4. Two wrong PINs, then a correct PIN -> unlock pulse and fail_cnt cleared to 0.
5. Two bits entered, then clear=1 together with key_valid=1 -> returns to IDLE, no has_access, fail_cnt unchanged. A fresh 4-bit entry then works normally.
6. rst_n asserted low mid-PRESENT and mid-GRANT -> has_access and unlock drop asynchronously, state=IDLE. card_ok=0 during COLLECT -> entry discarded.
